shift_rx: RTL and testbench

SHIFT_RX -- requirements
Module: shift_rx

---
 rtl/shift_rx_pkg.sv | 17 +
 rtl/shift_rx_sipo.sv | 47 ++++
 rtl/shift_rx.sv | 136 +++++++++++++
 tb/tb_shift_rx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_rx_pkg.sv
// shift_rx_pkg -- shared types and helpers for the shift_rx receiver.
//   state_t   : receiver FSM states (PAR is used only when SHIFT_RX_PARITY_EN
//               is defined).
//   cnt_width : width of a counter that can hold 0..width without wrapping.
package shift_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_rx_sipo.sv
// shift_rx_sipo -- serial-in / parallel-out shift register core.
//   clk, rst  : clock, asynchronous active-high reset (clears the register)
//   clr       : synchronous clear to zero (wins over en)
//   en        : shift one bit in this cycle
//   msb_first : 1 = shift left, sin enters bit 0;
//               0 = shift right, sin enters bit WIDTH-1
//   sin       : serial data bit
//   data_nxt  : value the register takes at the next edge. When en=0 and
//               clr=0 this equals the current register contents.
module shift_rx_sipo
  import shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             msb_first,
  input  logic             sin,
  output logic [WIDTH-1:0] data_nxt
);

  logic [WIDTH-1:0] data;

  always_comb begin
    data_nxt = data;
    if (clr) begin
      data_nxt = '0;
    end else if (en) begin
      if (msb_first) begin
        data_nxt = {data[WIDTH-2:0], sin};
      end else begin
        data_nxt = {sin, data[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else begin
      data <= data_nxt;
    end
  end

endmodule

// File: rtl/shift_rx.sv
// shift_rx -- framed serial receiver with a one-word output register.
// Optional feature: define SHIFT_RX_PARITY_EN to append an even-parity bit
// to each frame (PAR state) and report perr; otherwise perr is tied 0.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   start     : begin a new frame; aborts any frame in progress
//   sin       : serial data bit
//   sin_vld   : sin is valid this cycle
//   msb_first : 1 = first bit lands in q[WIDTH-1]; 0 = first bit in q[0]
//   q_ack     : consumer accepts q
//   q         : received word
//   q_vld     : q holds an unconsumed word
//   busy      : frame in progress
//   ovr       : sticky overrun flag (cleared only by rst)
//   perr      : parity error for the word in q
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             msb_first,
  input  logic             q_ack,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  output logic             busy,
  output logic             ovr,
  output logic             perr
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             shift_en;
  logic             last_bit;
  logic             done;

  // start has priority over data: the start cycle never samples sin.
  assign shift_en = (state == DATA) && sin_vld && !start;
  assign last_bit = shift_en && (cnt == CW'(WIDTH - 1));

`ifdef SHIFT_RX_PARITY_EN
  assign done = (state == PAR) && sin_vld && !start;
`else
  assign done = last_bit;
`endif

  // word is the shift register's next value: on the last data bit it
  // already includes that bit, and in PAR (no shift) it is the held data.
  shift_rx_sipo #(
    .WIDTH(WIDTH)
  ) u_sipo (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .en       (shift_en),
    .msb_first(msb_first),
    .sin      (sin),
    .data_nxt (word)
  );

  // FSM and bit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      state <= DATA;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        DATA: begin
          if (shift_en) begin
            cnt <= cnt + 1'b1;
          end
          if (last_bit) begin
`ifdef SHIFT_RX_PARITY_EN
            state <= PAR;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
        PAR: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output register, overrun and parity flags
`ifdef SHIFT_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr <= 1'b0;
    end else if (done && (!q_vld || q_ack)) begin
      // Even parity: data bits plus parity bit must XOR to 0.
      perr <= (^word) ^ sin;
    end
  end
`else
  assign perr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      q_vld <= 1'b0;
      ovr   <= 1'b0;
    end else if (done) begin
      if (!q_vld || q_ack) begin
        q     <= word;
        q_vld <= 1'b1;
      end else begin
        ovr <= 1'b1;
      end
    end else if (q_ack) begin
      q_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_rx.sv
module tb_shift_rx;
  import shift_rx_pkg::*;

  localparam int unsigned W = 4;
`ifdef SHIFT_RX_PARITY_EN
  localparam int unsigned FLEN = W + 1;
`else
  localparam int unsigned FLEN = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sin = 1'b0;
  logic         sin_vld = 1'b0;
  logic         msb_first = 1'b0;
  logic         q_ack = 1'b0;
  logic [W-1:0] q;
  logic         q_vld;
  logic         busy;
  logic         ovr;
  logic         perr;

  shift_rx #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sin      (sin),
    .sin_vld  (sin_vld),
    .msb_first(msb_first),
    .q_ack    (q_ack),
    .q        (q),
    .q_vld    (q_vld),
    .busy     (busy),
    .ovr      (ovr),
    .perr     (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard entry: word and perr expected, and the cycle it must appear.
  typedef struct {
    logic [W-1:0] w;
    logic         p;
    int           c;
  } exp_t;
  exp_t sb[$];

  // Reference model state: frame in progress, collected bits, output status.
  bit   in_frame = 0;
  bit   f_msb = 0;
  bit   fbits[$];
  bit   m_vld = 0;
  bit   m_ovr = 0;
  logic cur_msb = 1'b0;

  task automatic model_done(input bit ack);
    exp_t e;
    logic [W-1:0] w;
    logic p;
    w = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (f_msb) w[W-1-i] = fbits[i];
      else       w[i]     = fbits[i];
    end
    p = 1'b0;
`ifdef SHIFT_RX_PARITY_EN
    for (int i = 0; i < int'(FLEN); i++) p = p ^ fbits[i];
`endif
    if (!m_vld || ack) begin
      e.w = w;
      e.p = p;
      e.c = cyc + 1;
      sb.push_back(e);
      m_vld = 1;
    end else begin
      m_ovr = 1;
    end
  endtask

  // One clock: drive at negedge, update model, check levels after the edge.
  task automatic drive(input bit st, input bit b, input bit v, input bit ack);
    bit done;
    @(negedge clk);
    start = st; sin = b; sin_vld = v; q_ack = ack; msb_first = cur_msb;
    done = 0;
    if (st) begin
      fbits.delete();
      in_frame = 1;
      f_msb = cur_msb;
    end else if (in_frame && v) begin
      fbits.push_back(b);
      if (fbits.size() == FLEN) begin
        done = 1;
        in_frame = 0;
      end
    end
    if (done) model_done(ack);
    else if (ack) m_vld = 0;
    @(posedge clk);
    #1;
    chk("busy", 32'(busy), 32'(in_frame));
    chk("q_vld", 32'(q_vld), 32'(m_vld));
    chk("ovr", 32'(ovr), 32'(m_ovr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // seq[W-1] is sent first. gap = idle cycles before each bit.
  task automatic send_frame(input logic msb, input logic [W-1:0] seq, input int gap,
                            input bit ack_last, input bit par_flip);
    logic [FLEN-1:0] fr;
    cur_msb = msb;
`ifdef SHIFT_RX_PARITY_EN
    fr = {seq, (^seq) ^ par_flip};
`else
    fr = seq;
    if (par_flip) fr = seq;
`endif
    drive(1, 0, 0, 0);
    for (int i = int'(FLEN) - 1; i >= 0; i--) begin
      for (int g = 0; g < gap; g++) drive(0, 1'($urandom), 0, 0);
      drive(0, fr[i], 1, (i == 0) && ack_last);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; sin_vld = 1'b0; q_ack = 1'b0;
    #1;
    chk("rst_q", 32'(q), 0);
    chk("rst_q_vld", 32'(q_vld), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_perr", 32'(perr), 0);
    in_frame = 0; fbits.delete(); m_vld = 0; m_ovr = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: a new word is presented when q_vld is 1 and either it was 0
  // after the previous edge or the consumer acknowledged at this edge.
  initial begin
    bit prev_vld;
    exp_t e;
    prev_vld = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_vld = 0;
        continue;
      end
      if (q_vld && (!prev_vld || q_ack)) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(q), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("q", 32'(q), 32'(e.w));
          chk("perr", 32'(perr), 32'(e.p));
          chk("latency", 32'(cyc), 32'(e.c));
        end
      end
      prev_vld = q_vld;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();
    idle(2);

    // msb-first, consecutive bits
    send_frame(1, 4'b1011, 0, 0, 0);
    chk("q_1011", 32'(q), 32'hB);
    idle(1);
    drive(0, 0, 0, 1);

    // lsb-first with 2-cycle gaps
    send_frame(0, 4'b1011, 2, 0, 0);
    chk("q_1101", 32'(q), 32'hD);
    drive(0, 0, 0, 1);

    // overrun: second word dropped
    send_frame(1, 4'b0011, 0, 0, 0);
    send_frame(1, 4'b1100, 0, 0, 0);
    chk("ovr_q_kept", 32'(q), 32'h3);
    chk("ovr_set", 32'(ovr), 1);
    drive(0, 0, 0, 1);
    idle(2);

    // reset mid-frame, then bits without start are ignored
    cur_msb = 1'b1;
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);
    do_reset();
    for (int i = 0; i < 4; i++) drive(0, 1, 1, 0);
    chk("no_start_q_vld", 32'(q_vld), 0);

    // abort after 2 bits, restart
    cur_msb = 1'b1;
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    drive(0, 1, 1, 0);
    send_frame(1, 4'b1111, 0, 0, 0);
    chk("abort_q", 32'(q), 32'hF);
    chk("abort_ovr", 32'(ovr), 0);

    // completion and ack in the same cycle
    send_frame(0, 4'b0110, 1, 1, 0);
    chk("same_cycle_q_vld", 32'(q_vld), 1);
    chk("same_cycle_ovr", 32'(ovr), 0);
    drive(0, 0, 0, 1);

`ifdef SHIFT_RX_PARITY_EN
    send_frame(1, 4'b1011, 0, 1, 0);
    chk("par_ok", 32'(perr), 0);
    send_frame(1, 4'b1011, 0, 1, 1);
    chk("par_bad", 32'(perr), 1);
    drive(0, 0, 0, 1);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit st;
      st = ($urandom_range(0, 19) == 0);
      if (st) cur_msb = 1'($urandom);
      drive(st, 1'($urandom), ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 2));
    end

    idle(3);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
